// File: rtl/uart_rx_ctrl_if.sv
// Purpose: bundles the serial-side inputs and the receive-status outputs of
//          uart_rx_ctrl so the receiver can be wired as a single port.
// Signals:
//   baud_tick   - single-cycle enable at OVERSAMPLE x baud rate
//   rx          - synchronised serial line, idle high
//   rx_data     - last received word (DATA_BITS wide)
//   data_valid  - one-cycle pulse when rx_data / flags update
//   parity_err  - parity error for the word in rx_data
//   frame_err   - stop bit(s) sampled low for the word in rx_data
//   shift_bit   - one-cycle pulse per data bit sampled
//   parity_load - one-cycle pulse when the parity bit is sampled
//   check_stop  - one-cycle pulse per stop bit sampled
//   busy        - receiver is inside a frame
// Modports: master drives the line and observes status; slave is the receiver.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 shift_bit;
    logic                 parity_load;
    logic                 check_stop;
    logic                 busy;

    modport master (
        output baud_tick, rx,
        input  rx_data, data_valid, parity_err, frame_err,
               shift_bit, parity_load, check_stop, busy
    );

    modport slave (
        input  baud_tick, rx,
        output rx_data, data_valid, parity_err, frame_err,
               shift_bit, parity_load, check_stop, busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Purpose: parametrised UART receive controller. Oversamples the synchronised
//          rx line, sequences start/data/parity/stop bits, assembles the word
//          LSB first and reports parity and framing status.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - uart_rx_ctrl_if.slave (baud_tick/rx in; data, flags, pulses, busy out)
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PEN_BIT   = (PARITY_EN != 0);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbit_q, pbit_d;
    logic                 frame_q, frame_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 shift_bit_q, shift_bit_d;
    logic                 pload_q, pload_d;
    logic                 cstop_q, cstop_d;
    logic                 busy_q, busy_d;
    logic                 sample_c;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pbit_d      = pbit_q;
        frame_d     = frame_q;
        rx_data_d   = rx_data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        valid_d     = 1'b0;
        shift_bit_d = 1'b0;
        pload_d     = 1'b0;
        cstop_d     = 1'b0;
        sample_c    = 1'b0;

        // DATA/PARITY/STOP share one full-bit tick counter; sample at its wrap.
        if (bus.baud_tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
            if (tick_q == FULL_TICK) begin
                tick_d   = '0;
                sample_c = 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.baud_tick && !bus.rx) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    if (tick_q == MID_TICK) begin
                        if (bus.rx) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            frame_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_c) begin
                    shift_d     = {bus.rx, shift_q[DATA_BITS-1:1]};
                    shift_bit_d = 1'b1;
                    bit_d       = bit_q + 1'b1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = PEN_BIT ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample_c) begin
                    pbit_d  = bus.rx;
                    pload_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_c) begin
                    cstop_d = 1'b1;
                    if (!bus.rx) begin
                        frame_d = 1'b1;
                    end
                    if (bit_q == LAST_STOP) begin
                        // Leave at mid stop bit so a back-to-back start edge is caught.
                        state_d   = IDLE;
                        rx_data_d = shift_q;
                        perr_d    = PEN_BIT & (^shift_q ^ pbit_q ^ ODD_BIT);
                        ferr_d    = frame_q | ~bus.rx;
                        valid_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            pbit_q      <= 1'b0;
            frame_q     <= 1'b0;
            rx_data_q   <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            shift_bit_q <= 1'b0;
            pload_q     <= 1'b0;
            cstop_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            pbit_q      <= pbit_d;
            frame_q     <= frame_d;
            rx_data_q   <= rx_data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            shift_bit_q <= shift_bit_d;
            pload_q     <= pload_d;
            cstop_q     <= cstop_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.data_valid  = valid_q;
    assign bus.parity_err  = perr_q;
    assign bus.frame_err   = ferr_q;
    assign bus.shift_bit   = shift_bit_q;
    assign bus.parity_load = pload_q;
    assign bus.check_stop  = cstop_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int unsigned OS_A = 16;
    localparam int unsigned OS_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DATA_BITS(8)) if_a ();
    uart_rx_ctrl_if #(.DATA_BITS(7)) if_b ();

    // 8E1, oversample 16
    uart_rx_ctrl #(
        .DATA_BITS(8), .OVERSAMPLE(OS_A), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );

    // 7N2, oversample 8
    uart_rx_ctrl #(
        .DATA_BITS(7), .OVERSAMPLE(OS_B), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int data;
        int perr;
        int ferr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int sa = 0, pa = 0, ca = 0;
    int sb = 0, pb = 0, cb = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_a();
        return int'({if_a.busy, if_a.check_stop, if_a.parity_load, if_a.shift_bit,
                     if_a.frame_err, if_a.parity_err, if_a.data_valid, if_a.rx_data});
    endfunction

    function automatic int outs_b();
        return int'({if_b.busy, if_b.check_stop, if_b.parity_load, if_b.shift_bit,
                     if_b.frame_err, if_b.parity_err, if_b.data_valid, if_b.rx_data});
    endfunction

    // One baud_tick pulse followed by 0..2 idle clocks.
    task automatic baud(input int inst);
        @(negedge clk);
        if (inst == 0) if_a.baud_tick = 1'b1;
        else           if_b.baud_tick = 1'b1;
        @(negedge clk);
        if_a.baud_tick = 1'b0;
        if_b.baud_tick = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) if_a.rx = v;
        else           if_b.rx = v;
    endtask

    // Hold each line bit for a full bit period, then idle for gap ticks.
    task automatic drive(input int inst, input logic [15:0] fv, input int nbits, input int gap);
        int os;
        os = (inst == 0) ? int'(OS_A) : int'(OS_B);
        for (int i = 0; i < nbits; i++) begin
            set_rx(inst, fv[i]);
            repeat (os) baud(inst);
        end
        set_rx(inst, 1'b1);
        repeat (gap) baud(inst);
    endtask

    // 8E1 frame: expected parity error when data ones + parity bit is odd.
    task automatic send_a(input logic [7:0] data, input logic pbit, input logic stop, input int gap);
        logic [15:0] fv;
        exp_t e;
        fv = '1;
        fv[0] = 1'b0;
        for (int i = 0; i < 8; i++) fv[1+i] = data[i];
        fv[9]  = pbit;
        fv[10] = stop;
        e.data = int'(data);
        e.perr = (int'($countones(data)) + int'(pbit)) % 2;
        e.ferr = stop ? 0 : 1;
        qa.push_back(e);
        drive(0, fv, 11, gap);
    endtask

    // 7N2 frame: framing error when either stop bit is low.
    task automatic send_b(input logic [6:0] data, input logic s1, input logic s2, input int gap);
        logic [15:0] fv;
        exp_t e;
        fv = '1;
        fv[0] = 1'b0;
        for (int i = 0; i < 7; i++) fv[1+i] = data[i];
        fv[8] = s1;
        fv[9] = s2;
        e.data = int'(data);
        e.perr = 0;
        e.ferr = (s1 && s2) ? 0 : 1;
        qb.push_back(e);
        drive(1, fv, 10, gap);
    endtask

    // Scoreboard monitor for instance A.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sa = 0; pa = 0; ca = 0;
        end else begin
            if (if_a.shift_bit)   sa++;
            if (if_a.parity_load) pa++;
            if (if_a.check_stop)  ca++;
            if (if_a.data_valid) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_valid", 1, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_rx_data", int'(if_a.rx_data), e.data);
                    check("a_parity_err", int'(if_a.parity_err), e.perr);
                    check("a_frame_err", int'(if_a.frame_err), e.ferr);
                    check("a_shift_pulses", sa, 8);
                    check("a_parity_pulses", pa, 1);
                    check("a_stop_pulses", ca, 1);
                    check("a_busy_at_valid", int'(if_a.busy), 0);
                end
                sa = 0; pa = 0; ca = 0;
            end
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb = 0; pb = 0; cb = 0;
        end else begin
            if (if_b.shift_bit)   sb++;
            if (if_b.parity_load) pb++;
            if (if_b.check_stop)  cb++;
            if (if_b.data_valid) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_valid", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_rx_data", int'(if_b.rx_data), e.data);
                    check("b_parity_err", int'(if_b.parity_err), e.perr);
                    check("b_frame_err", int'(if_b.frame_err), e.ferr);
                    check("b_shift_pulses", sb, 7);
                    check("b_parity_pulses", pb, 0);
                    check("b_stop_pulses", cb, 2);
                    check("b_busy_at_valid", int'(if_b.busy), 0);
                end
                sb = 0; pb = 0; cb = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d8;
        logic [6:0]  d7;
        logic [15:0] fv;
        logic        pb_r, st_r, s1, s2;
        int          waitc;

        if_a.rx = 1'b1; if_a.baud_tick = 1'b0;
        if_b.rx = 1'b1; if_b.baud_tick = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs_a", outs_a(), 0);
        check("reset_outs_b", outs_b(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 0xA5, good parity and stop
        send_a(8'hA5, 1'b0, 1'b1, OS_A);
        check("t1_busy_idle", int'(if_a.busy), 0);

        // Frame 0xA5 with wrong parity bit
        send_a(8'hA5, 1'b1, 1'b1, OS_A);

        // Frame 0x3C, good parity, stop bit low
        send_a(8'h3C, 1'b0, 1'b0, OS_A + 4);

        // False start: rx low for 4 ticks then high
        set_rx(0, 1'b0);
        baud(0);
        check("fs_busy_high", int'(if_a.busy), 1);
        repeat (3) baud(0);
        set_rx(0, 1'b1);
        repeat (6) baud(0);
        check("fs_busy_low", int'(if_a.busy), 0);
        check("fs_rx_data_held", int'(if_a.rx_data), 8'h3C);
        check("fs_frame_err_held", int'(if_a.frame_err), 1);
        check("fs_parity_err_held", int'(if_a.parity_err), 0);

        // Reset after 3 data bits of a frame
        fv = '1;
        fv[0] = 1'b0;
        d8 = 8'hFF;
        for (int i = 0; i < 8; i++) fv[1+i] = d8[i];
        for (int i = 0; i < 4; i++) begin
            set_rx(0, fv[i]);
            repeat (OS_A) baud(0);
        end
        check("abort_busy_before", int'(if_a.busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outs_a", outs_a(), 0);
        set_rx(0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_a(8'h3C, 1'b0, 1'b1, OS_A);

        // 7N2: 0x55 with second stop bit low
        send_b(7'h55, 1'b1, 1'b0, OS_B);
        send_b(7'h2A, 1'b1, 1'b1, OS_B);

        // Randomized 8E1 frames
        for (int n = 0; n < 30; n++) begin
            d8   = 8'($urandom_range(0, 255));
            pb_r = 1'(($countones(d8)) % 2);
            if ($urandom_range(0, 4) == 0) pb_r = ~pb_r;
            st_r = ($urandom_range(0, 4) != 0);
            send_a(d8, pb_r, st_r, st_r ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20)));
        end

        // Randomized 7N2 frames
        for (int n = 0; n < 20; n++) begin
            d7 = 7'($urandom_range(0, 127));
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            send_b(d7, s1, s2, s2 ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12)));
        end

        waitc = 0;
        while ((qa.size() != 0 || qb.size() != 0) && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
        check("final_busy_a", int'(if_a.busy), 0);
        check("final_busy_b", int'(if_b.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller with an integrated datapath. It oversamples the synchronised serial line and sequences start, data, parity and stop bits. It assembles the received word and reports parity and framing status. It replaces the fixed 8N1 receive FSM and sits between the rx input synchroniser and the receive FIFO / host interface. Word length, parity mode, stop-bit count and oversampling ratio are compile-time selectable.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
OVERSAMPLE, 16, baud_tick pulses per bit period; even, >=4
PARITY_EN, 1, 1 = parity bit present in the frame; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked; 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
baud_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate
rx  input  1  serial line, already synchronised to clk; idle high
rx_data  output  DATA_BITS  last received word, LSB first on the line
data_valid  output  1  one-cycle pulse: rx_data and the status flags have been updated
parity_err  output  1  parity error for the word in rx_data
frame_err  output  1  one or more stop bits sampled low for the word in rx_data
shift_bit  output  1  one-cycle pulse per data bit sampled
parity_load  output  1  one-cycle pulse when the parity bit is sampled
check_stop  output  1  one-cycle pulse per stop bit sampled
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; tick counter, bit counter and shift register cleared.
  - All outputs 0, including rx_data.
- States: IDLE, START, DATA, PARITY, STOP. Only a clk edge with baud_tick=1 advances counters or samples rx. Without baud_tick, the FSM holds.
- IDLE:
  - baud_tick=1 and rx=0 -> START, tick_cnt<=0.
  - rx=1 -> stay in IDLE.
- START:
  - tick_cnt increments on each baud_tick.
  - Sample at baud_tick with tick_cnt==OVERSAMPLE/2-1 (mid start bit).
  - rx=1 -> false start: return to IDLE; no pulses, flags unchanged.
  - rx=0 -> DATA, tick_cnt<=0, bit_cnt<=0.
- DATA / PARITY / STOP sampling: sample at baud_tick with tick_cnt==OVERSAMPLE-1, then tick_cnt<=0. This places every sample at mid-bit.
- DATA:
  - On each sample, shift_reg <= {rx, shift_reg[DATA_BITS-1:1]} and bit_cnt++.
  - After DATA_BITS samples -> PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - Capture pbit.
  - Next state STOP.
- STOP:
  - Each sample with rx=0 sets an internal frame flag.
  - After STOP_BITS samples -> IDLE.
- Final stop sample edge: rx_data<=shift_reg; parity_err<=PARITY_EN & (^shift_reg ^ pbit ^ PARITY_ODD); frame_err<=frame flag; data_valid=1 for exactly one cycle.
  - Flags and rx_data hold until the next data_valid.
  - A frame with a framing error is still delivered.
- Output timing: all outputs are registered. shift_bit, parity_load and check_stop are high in the cycle after their sampling edge. The final check_stop coincides with data_valid.
- busy:
  - Rises the cycle after start detection.
  - Falls the cycle after the final stop sample.
  - A false start drops busy the cycle after the mid-start sample.
- Back-to-back frames: the FSM returns to IDLE at mid stop bit. A falling edge on the next start bit is detected on the first baud_tick seeing rx=0.
- rx changes between samples are ignored. There is no majority voting.

Test Plan:
1. Defaults (8E1, OVERSAMPLE=16), frame 0xA5 with parity bit 0 and stop 1 -> 8 shift_bit pulses, 1 parity_load, 1 check_stop; data_valid for 1 cycle with rx_data=8'hA5, parity_err=0, frame_err=0; busy low afterwards.
2. Frame 0xA5 with parity bit 1 -> rx_data=8'hA5, parity_err=1, frame_err=0.
3. Frame 0x3C, correct parity, stop bit driven 0 -> data_valid with rx_data=8'h3C, frame_err=1, parity_err=0.
4. rx low for 4 baud_ticks, then high -> no shift_bit and no data_valid; busy high then low; FSM back in IDLE; flags unchanged.
5. rst pulsed after 3 data bits of a frame -> all outputs 0 in the same cycle. A following frame 0x3C is received correctly with no residue from the aborted frame.
6. DATA_BITS=7, PARITY_EN=0, STOP_BITS=2: frame 0x55 with second stop bit 0 -> 7 shift_bit pulses, 0 parity_load, 2 check_stop pulses; rx_data=7'h55, frame_err=1, parity_err=0.
